ftdi_tx_arbiter: RTL and testbench
==================================

# ftdi_tx_arbiter

Round-robin packet arbiter that shares the `ftdi_245fifo` user write stream among `NCH` independent requesters. Each granted requester's packet is prefixed with a one-word header carrying channel id and length, so host software can demultiplex the USB byte stream. The block sits between the user-side data sources and the `itvalid/itready/itdata` port of `ftdi_245fifo`, in the same clock domain as `iclk`.

## Interface

**Parameters**
- `NCH`, default 4: number of requesters, 2..256.
- `DSIZE`, default 4: word width in bytes, ≥4. Must equal `INPUT_DSIZE` of `ftdi_245fifo`.

**Ports**
- `clk` in 1: single clock; drives `iclk` of `ftdi_245fifo`.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_tvalid` in NCH: per-requester valid.
- `s_tready` out NCH: per-requester ready. At most one bit is high at any time.
- `s_tdata` in NCH·DSIZE·8: requester `i` occupies slice `[i*DSIZE*8 +: DSIZE*8]`.
- `s_tlast` in NCH: marks the last word of a packet.
- `s_tlen` in NCH·16: per-requester length field, equal to beats−1. Sampled at grant.
- `m_tvalid` out 1: connects to `itvalid`.
- `m_tready` in 1: connects to `itready`.
- `m_tdata` out DSIZE·8: connects to `itdata`.
- `busy` out 1: high while the state is not IDLE.
- `cur_ch` out 8: index of the granted channel. Holds its last value while IDLE.
- `len_err` out 1: one-cycle pulse on a length/tlast mismatch.

## Operation

**States: IDLE, HDR, DATA.**

- **IDLE**
  - Search `s_tvalid` round-robin, starting at `ptr`.
  - On the first set bit `i`: latch `cur_ch=i` and `len=s_tlen[i]`, set `ptr=(i+1) mod NCH`, go to HDR.
  - No data is accepted in IDLE.
- **HDR**
  - Write the header into the output stage when it has space, then go to DATA.
  - Header layout: `[31:24]=8'hA5`, `[23:16]=cur_ch`, `[15:0]=len`. Bits above 31 are zero.
- **DATA**
  - `s_tready[cur_ch]` is high iff the output stage can accept a word.
  - Each accepted beat (`s_tvalid & s_tready`) is copied into the output stage and increments a 16-bit beat counter `cnt`. The counter is cleared on grant.
  - **Normal end:** the beat with `cnt==len` and `s_tlast=1` ends the packet. Go to IDLE, no error.
  - **Early tlast:** a beat with `s_tlast=1` and `cnt<len` ends the packet and pulses `len_err`. Go to IDLE.
  - **Missing tlast:** the beat with `cnt==len` and `s_tlast=0` ends the packet and pulses `len_err`. Go to IDLE. That channel's remaining words form its next packet.
- **Output stage:** 2-entry skid buffer.
  - `m_tvalid` and `m_tdata` are driven straight from flops.
  - Internal "can accept" is registered, so there is no combinational path from `m_tready` to `s_tready`.
  - The buffer never drops or duplicates a word. Order out equals order in.
- **Round-robin pointer `ptr`:** reset value 0; advances only on grant.
- **Counter width:** 16 bits. `len=16'hFFFF` means 65536 beats and must not wrap early.

## Timing

- **Reset values:** `m_tvalid=0`, `m_tdata=0`, `s_tready=0`, `busy=0`, `cur_ch=0`, `len_err=0`, state IDLE, `ptr=0`, skid buffer empty.
- **Reset mid-packet:** everything returns to the reset values immediately (asynchronous). Partially delivered packets are abandoned; words held in the skid buffer are discarded.
- **Grant latency:**
  - Cycle N: IDLE with a requester valid.
  - Cycle N+1: HDR.
  - Cycle N+2: header visible on `m_tdata` with `m_tvalid=1`, provided the buffer was empty.
  - `s_tready[cur_ch]` may first be high in cycle N+2.
- **Data latency:** a word accepted in cycle k appears on `m_tdata` no earlier than k+1.
- **Throughput:** 1 word/cycle in DATA while `m_tready=1`.
- **Packet overhead:** per packet, 1 header word plus 1 IDLE arbitration cycle.
- **`len_err`:** asserted in the cycle after the terminating beat, for exactly 1 cycle.
- **Simultaneous requests:** resolved by `ptr` only. A requester that deasserts `s_tvalid` while in IDLE loses nothing.
- **Stalls:** `m_tready=0` indefinitely stalls the block with all state held. `m_tvalid` stays high and `m_tdata` stable while not accepted.

## Test plan

1. **Single packet.** Stimulus: `NCH=4`, `DSIZE=4`, ch1 sends `s_tlen=2` with words 0x11111111, 0x22222222, 0x33333333 (tlast on the third), `m_tready=1`. Response: `m_tdata` = 0xA5010002, 0x11111111, 0x22222222, 0x33333333; `len_err` stays 0; `busy` returns to 0.
2. **Fairness.** Stimulus: ch0 and ch2 continuously valid with 1-word packets (`s_tlen=0`). Response: headers alternate 0xA5000000, 0xA5020000, 0xA5000000, …; no channel is granted twice in a row.
3. **Backpressure.** Stimulus: `m_tready` driven by a random 50% pattern during a 100-word packet on ch3. Response: 101 output words in exact order, no loss or duplication, and `m_tdata` stable whenever `m_tvalid & !m_tready`.
4. **Early tlast.** Stimulus: ch0 with `s_tlen=4` asserts tlast on beat 2. Response: 1 header + 2 data words; `len_err` pulses for 1 cycle; the next grant proceeds normally.
5. **Missing tlast.** Stimulus: ch0 with `s_tlen=1` sends 3 words, tlast only on the third, then `s_tlen=0`. Response: first packet has 2 words and `len_err` pulses; second packet is header 0xA5000000 plus the third word.
6. **Reset mid-packet.** Stimulus: `rst_n` pulled low during DATA with the skid buffer full. Response: `m_tvalid=0` and `s_tready=0` immediately; after release, the next grant starts from ch0.

Source files
------------

// File: rtl/ftdi_tx_arbiter_if.sv
// ftdi_tx_arbiter_if
//   Bundles the requester-side streams, the ftdi_245fifo write stream and the
//   status outputs of ftdi_tx_arbiter.
//   master : arbiter view (drives s_tready, m_*, busy, cur_ch, len_err)
//   slave  : environment view (drives s_tvalid/s_tdata/s_tlast/s_tlen, m_tready)
//   s_tdata[i] / s_tlen[i] are bit-identical to the flat slices
//   [i*DSIZE*8 +: DSIZE*8] / [i*16 +: 16].
interface ftdi_tx_arbiter_if #(
  parameter int NCH   = 4,
  parameter int DSIZE = 4
);
  localparam int W = DSIZE * 8;

  logic [NCH-1:0]         s_tvalid;
  logic [NCH-1:0]         s_tready;
  logic [NCH-1:0][W-1:0]  s_tdata;
  logic [NCH-1:0]         s_tlast;
  logic [NCH-1:0][15:0]   s_tlen;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [W-1:0]           m_tdata;
  logic                   busy;
  logic [7:0]             cur_ch;
  logic                   len_err;

  modport master (
    input  s_tvalid, s_tdata, s_tlast, s_tlen, m_tready,
    output s_tready, m_tvalid, m_tdata, busy, cur_ch, len_err
  );

  modport slave (
    output s_tvalid, s_tdata, s_tlast, s_tlen, m_tready,
    input  s_tready, m_tvalid, m_tdata, busy, cur_ch, len_err
  );
endinterface

// File: rtl/ftdi_tx_arbiter.sv
// ftdi_tx_arbiter
//   Round-robin packet arbiter feeding the ftdi_245fifo user write stream.
//   Each granted packet is prefixed with a header word
//   {8'hA5, cur_ch, len} (upper bits zero) so the host can demultiplex.
// Ports
//   clk   : clock (same domain as ftdi_245fifo iclk)
//   rst_n : asynchronous active-low reset
//   bus   : ftdi_tx_arbiter_if.master (requester streams, output stream, status)
module ftdi_tx_arbiter #(
  parameter int NCH   = 4,
  parameter int DSIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ftdi_tx_arbiter_if.master    bus
);
  localparam int W = DSIZE * 8;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t       r_state, w_nstate;
  logic [7:0]   r_ptr, r_cur_ch, w_gnt;
  logic         w_found;
  logic [15:0]  r_len, r_cnt, w_gnt_len;
  logic         r_len_err;

  // 2-entry output stage: head drives the port, skid catches one extra word
  logic         r_hd_v, r_sk_v;
  logic [W-1:0] r_hd_d, r_sk_d;

  logic         w_push, w_pop, w_data_rdy, w_beat, w_cnt_end, w_end;
  logic         w_sel_v, w_sel_last;
  logic [W-1:0] w_sel_d, w_din, w_hdr;

  // Round-robin search: lowest valid index >= ptr wins, else lowest valid
  // index below ptr. Descending loops so the lowest index is assigned last.
  always_comb begin
    w_found   = 1'b0;
    w_gnt     = '0;
    w_gnt_len = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (bus.s_tvalid[i] && (8'(i) < r_ptr)) begin
        w_found = 1'b1; w_gnt = 8'(i); w_gnt_len = bus.s_tlen[i];
      end
    for (int i = NCH - 1; i >= 0; i--)
      if (bus.s_tvalid[i] && (8'(i) >= r_ptr)) begin
        w_found = 1'b1; w_gnt = 8'(i); w_gnt_len = bus.s_tlen[i];
      end
  end

  // Granted channel mux
  always_comb begin
    w_sel_v    = 1'b0;
    w_sel_last = 1'b0;
    w_sel_d    = '0;
    for (int i = 0; i < NCH; i++)
      if (r_cur_ch == 8'(i)) begin
        w_sel_v    = bus.s_tvalid[i];
        w_sel_last = bus.s_tlast[i];
        w_sel_d    = bus.s_tdata[i];
      end
  end

  always_comb begin
    w_hdr       = '0;
    w_hdr[31:0] = {8'hA5, r_cur_ch, r_len};
  end

  // Space in the output stage is simply "skid empty", a flop, so s_tready
  // never depends combinationally on m_tready.
  assign w_beat    = (r_state == DATA) && w_sel_v && !r_sk_v;
  assign w_cnt_end = (r_cnt == r_len);
  assign w_end     = w_beat && (w_sel_last || w_cnt_end);
  assign w_pop     = r_hd_v && bus.m_tready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;

  // FSM: next state
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (w_found) w_nstate = HDR;
      HDR:     if (!r_sk_v) w_nstate = DATA;
      DATA:    if (w_end)   w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_push     = 1'b0;
    w_din      = w_sel_d;
    w_data_rdy = 1'b0;
    case (r_state)
      HDR: begin
        w_push = !r_sk_v;
        w_din  = w_hdr;
      end
      DATA: begin
        w_data_rdy = !r_sk_v;
        w_push     = w_beat;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.s_tready = '0;
    for (int i = 0; i < NCH; i++)
      bus.s_tready[i] = w_data_rdy && (r_cur_ch == 8'(i));
  end

  // Grant / beat bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ptr     <= '0;
      r_cur_ch  <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_found) begin
        r_cur_ch <= w_gnt;
        r_len    <= w_gnt_len;
        r_cnt    <= '0;
        r_ptr    <= (w_gnt == 8'(NCH - 1)) ? 8'd0 : w_gnt + 8'd1;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 16'd1;
      end
      // error when tlast and the length count disagree on the ending beat
      r_len_err <= w_end && (w_sel_last ^ w_cnt_end);
    end

  // Output stage. Pushes only happen while skid is empty.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hd_v <= 1'b0;
      r_sk_v <= 1'b0;
      r_hd_d <= '0;
      r_sk_d <= '0;
    end else if (r_sk_v) begin
      if (w_pop) begin
        r_hd_d <= r_sk_d;
        r_sk_v <= 1'b0;
      end
    end else if (w_push && r_hd_v && !w_pop) begin
      r_sk_v <= 1'b1;
      r_sk_d <= w_din;
    end else if (w_push) begin
      r_hd_v <= 1'b1;
      r_hd_d <= w_din;
    end else if (w_pop) begin
      r_hd_v <= 1'b0;
    end

  assign bus.m_tvalid = r_hd_v;
  assign bus.m_tdata  = r_hd_d;
  assign bus.busy     = (r_state != IDLE);
  assign bus.cur_ch   = r_cur_ch;
  assign bus.len_err  = r_len_err;
endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
module tb_ftdi_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ftdi_tx_arbiter_if #(.NCH(4), .DSIZE(4)) bus ();
  ftdi_tx_arbiter #(.NCH(4), .DSIZE(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] wd;
    logic        last;
    logic [15:0] len;
    logic        evld;
    logic [31:0] edat;
    logic [3:0]  erdy;
    logic        ebusy;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] vld, logic [31:0] wd, logic last, logic [15:0] len,
                              logic evld, logic [31:0] edat, logic [3:0] erdy, logic ebusy, logic eerr);
    vec_t v;
    v.vld = vld; v.wd = wd; v.last = last; v.len = len;
    v.evld = evld; v.edat = edat; v.erdy = erdy; v.ebusy = ebusy; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic [31:0] wd, input logic last, input logic [15:0] len);
    bus.s_tvalid = vld;
    bus.s_tlast  = {4{last}};
    for (int i = 0; i < 4; i++) begin
      bus.s_tdata[i] = wd;
      bus.s_tlen[i]  = len;
    end
  endtask

  // drop all requests once the arbiter is IDLE, then wait for the output to empty
  task automatic drain_idle(input string nm);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (!bus.busy) begin bus.s_tvalid = '0; break; end
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (!bus.m_tvalid) break;
    end
    chk(nm, {30'b0, bus.busy, bus.m_tvalid}, 32'h0);
  endtask

  initial begin
    logic [31:0] words[$];
    int          got, idx;
    logic        prev_stall;
    logic [31:0] prev_data, expw;

    drive(4'b0000, 32'h0, 1'b0, 16'h0);
    bus.m_tready = 1'b1;

    // ---------------- reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst.m_tvalid", {31'b0, bus.m_tvalid}, 32'h0);
    chk("rst.m_tdata",  bus.m_tdata, 32'h0);
    chk("rst.s_tready", {28'b0, bus.s_tready}, 32'h0);
    chk("rst.busy",     {31'b0, bus.busy}, 32'h0);
    chk("rst.cur_ch",   {24'b0, bus.cur_ch}, 32'h0);
    chk("rst.len_err",  {31'b0, bus.len_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table: single packet, early tlast, missing tlast
    // single packet on ch1, len 2
    tbl.push_back(mk(4'b0010, 32'h11111111, 0, 16'd2, 0, 32'h0,        4'b0000, 0, 0));
    tbl.push_back(mk(4'b0010, 32'h11111111, 0, 16'd2, 0, 32'h0,        4'b0000, 1, 0));
    tbl.push_back(mk(4'b0010, 32'h11111111, 0, 16'd2, 1, 32'hA5010002, 4'b0010, 1, 0));
    tbl.push_back(mk(4'b0010, 32'h22222222, 0, 16'd2, 1, 32'h11111111, 4'b0010, 1, 0));
    tbl.push_back(mk(4'b0010, 32'h33333333, 1, 16'd2, 1, 32'h22222222, 4'b0010, 1, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        0, 16'd0, 1, 32'h33333333, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        0, 16'd0, 0, 32'h0,        4'b0000, 0, 0));
    // early tlast on ch0: len 4, tlast on beat 2, then a normal 1-word packet
    tbl.push_back(mk(4'b0001, 32'hAAAA0001, 0, 16'd4, 0, 32'h0,        4'b0000, 0, 0));
    tbl.push_back(mk(4'b0001, 32'hAAAA0001, 0, 16'd4, 0, 32'h0,        4'b0000, 1, 0));
    tbl.push_back(mk(4'b0001, 32'hAAAA0001, 0, 16'd4, 1, 32'hA5000004, 4'b0001, 1, 0));
    tbl.push_back(mk(4'b0001, 32'hAAAA0002, 1, 16'd4, 1, 32'hAAAA0001, 4'b0001, 1, 0));
    tbl.push_back(mk(4'b0001, 32'hBBBB0001, 1, 16'd0, 1, 32'hAAAA0002, 4'b0000, 0, 1));
    tbl.push_back(mk(4'b0001, 32'hBBBB0001, 1, 16'd0, 0, 32'h0,        4'b0000, 1, 0));
    tbl.push_back(mk(4'b0001, 32'hBBBB0001, 1, 16'd0, 1, 32'hA5000000, 4'b0001, 1, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        0, 16'd0, 1, 32'hBBBB0001, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        0, 16'd0, 0, 32'h0,        4'b0000, 0, 0));
    // missing tlast on ch0: len 1, tlast only on word 3, then len 0
    tbl.push_back(mk(4'b0001, 32'hCCCC0001, 0, 16'd1, 0, 32'h0,        4'b0000, 0, 0));
    tbl.push_back(mk(4'b0001, 32'hCCCC0001, 0, 16'd1, 0, 32'h0,        4'b0000, 1, 0));
    tbl.push_back(mk(4'b0001, 32'hCCCC0001, 0, 16'd1, 1, 32'hA5000001, 4'b0001, 1, 0));
    tbl.push_back(mk(4'b0001, 32'hCCCC0002, 0, 16'd1, 1, 32'hCCCC0001, 4'b0001, 1, 0));
    tbl.push_back(mk(4'b0001, 32'hCCCC0003, 1, 16'd0, 1, 32'hCCCC0002, 4'b0000, 0, 1));
    tbl.push_back(mk(4'b0001, 32'hCCCC0003, 1, 16'd0, 0, 32'h0,        4'b0000, 1, 0));
    tbl.push_back(mk(4'b0001, 32'hCCCC0003, 1, 16'd0, 1, 32'hA5000000, 4'b0001, 1, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        0, 16'd0, 1, 32'hCCCC0003, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        0, 16'd0, 0, 32'h0,        4'b0000, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].wd, tbl[i].last, tbl[i].len);
      bus.m_tready = 1'b1;
      #1;
      chk($sformatf("v%0d.m_tvalid", i), {31'b0, bus.m_tvalid}, {31'b0, tbl[i].evld});
      if (tbl[i].evld) chk($sformatf("v%0d.m_tdata", i), bus.m_tdata, tbl[i].edat);
      chk($sformatf("v%0d.s_tready", i), {28'b0, bus.s_tready}, {28'b0, tbl[i].erdy});
      chk($sformatf("v%0d.busy", i),     {31'b0, bus.busy}, {31'b0, tbl[i].ebusy});
      chk($sformatf("v%0d.len_err", i),  {31'b0, bus.len_err}, {31'b0, tbl[i].eerr});
    end

    // ---------------- fairness: ch0 and ch2 always valid, 1-word packets
    drive(4'b0101, 32'h0, 1'b1, 16'h0);
    bus.s_tdata[0] = 32'hD0000000;
    bus.s_tdata[2] = 32'hD2000002;
    words.delete();
    for (int c = 0; c < 200 && words.size() < 16; c++) begin
      @(negedge clk); #1;
      if (bus.m_tvalid) words.push_back(bus.m_tdata);
    end
    chk("fair.count", words.size(), 32'd16);
    // ptr is 1 after the table, so ch2 comes first
    for (int p = 0; p < words.size() / 2; p++) begin
      chk($sformatf("fair.hdr%0d", p), words[2*p], (p % 2 == 0) ? 32'hA5020000 : 32'hA5000000);
      chk($sformatf("fair.dat%0d", p), words[2*p+1], (p % 2 == 0) ? 32'hD2000002 : 32'hD0000000);
    end
    drain_idle("fair.drain");

    // ---------------- backpressure: 100-word packet on ch3, random m_tready
    idx = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 2000 && got < 101; c++) begin
      @(negedge clk);
      drive((idx < 100) ? 4'b1000 : 4'b0000, 32'h30000000 + idx, (idx == 99), 16'd99);
      bus.m_tready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) chk("bp.stable", bus.m_tdata, prev_data);
      if ($countones(bus.s_tready) > 1) chk("bp.onehot", {28'b0, bus.s_tready}, 32'h8);
      if (bus.m_tvalid && bus.m_tready) begin
        expw = (got == 0) ? 32'hA5030063 : 32'h30000000 + got - 1;
        chk($sformatf("bp.w%0d", got), bus.m_tdata, expw);
        got++;
      end
      if (bus.s_tvalid[3] && bus.s_tready[3]) idx++;
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_data  = bus.m_tdata;
    end
    chk("bp.count", got, 32'd101);
    bus.m_tready = 1'b1;
    drain_idle("bp.drain");

    // ---------------- reset mid-packet with the output stage full
    @(negedge clk);
    drive(4'b0001, 32'hE0000001, 1'b0, 16'd10);
    bus.m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rmp.pre_vld",  {31'b0, bus.m_tvalid}, 32'h1);
    chk("rmp.pre_rdy",  {28'b0, bus.s_tready}, 32'h0);
    chk("rmp.pre_busy", {31'b0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rmp.m_tvalid", {31'b0, bus.m_tvalid}, 32'h0);
    chk("rmp.s_tready", {28'b0, bus.s_tready}, 32'h0);
    chk("rmp.busy",     {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0011, 32'hF0000000, 1'b1, 16'd0);
    bus.m_tready = 1'b1;
    @(negedge clk); #1;
    chk("rmp.cur_ch", {24'b0, bus.cur_ch}, 32'h0);
    chk("rmp.hdr_busy", {31'b0, bus.busy}, 32'h1);
    @(negedge clk); #1;
    chk("rmp.hdr_vld", {31'b0, bus.m_tvalid}, 32'h1);
    chk("rmp.hdr", bus.m_tdata, 32'hA5000000);
    drain_idle("rmp.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
